// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, line geometry and address helper for mem_bus_arbiter
//
// Purpose: state encoding of the arbiter FSM, cache-line geometry and the
// line alignment helper used when latching a request address.
// Ports: none (package).

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int LINE_BYTES       = 16;
    localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

    // Clears the byte-offset bits of an address. Works on a 64-bit value so
    // callers of any address width up to 64 can extend/truncate around it.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        logic [63:0] mask;
        mask = ~((64'd1 << LINE_OFFSET_BITS) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector
//
// Purpose: picks the first asserted request at or above ptr, wrapping to
// index 0, and reports it both one-hot and as a binary index.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority index for this decision
//   grant out NUM_REQ  one-hot grant (all zero when nothing requested)
//   index out IDX_W    binary index of the grant
//   any   out 1        at least one request present

module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    // Two passes over a fixed index range instead of a rotating index keeps
    // every vector access a constant select after unrolling: the first pass
    // only considers indices >= ptr, the second covers the wrapped part.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin sharing of one MEM_core port, single outstanding transaction
//
// Purpose: arbitrates NUM_REQ line requesters onto the MEM_core request
// port, keeps one transaction in flight, routes the response back to its
// owner and aborts transactions that never see a response.
// Ports:
//   clock, reset            clock (rising edge), async active-low reset
//   req_valid/ready/write   per-requester handshake and direction
//   req_addr, req_wdata     flattened per-requester address and write line
//   rsp_valid, rsp_error    per-requester response pulse, watchdog abort flag
//   rsp_data                shared read line
//   mem_req_*               request towards MEM_core (valid/ready handshake)
//   mem_rsp_valid/data      response from MEM_core
//   timeout_sticky          set by any watchdog abort until reset
//   grant_id                owner of the current or last transaction

module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int LINE_WIDTH = 128,
    parameter  int TIMEOUT    = 1024,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_error,
    output logic [LINE_WIDTH-1:0]            rsp_data,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_write,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [LINE_WIDTH-1:0]            mem_req_wdata,
    input  logic                             mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0]            mem_rsp_data,
    output logic                             timeout_sticky,
    output logic [IDX_W-1:0]                 grant_id
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     wd_cnt;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_index;
    logic                 arb_any;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;
    logic                  sel_write;

    logic [NUM_REQ-1:0]   owner_onehot;
    logic [IDX_W-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    // Accept pulse is only offered while idle and out of reset, so the
    // other requesters see req_ready=0 for the whole transaction.
    assign req_ready = (state == IDLE && reset) ? arb_grant : '0;

    // Select the granted requester's fields; one-hot grant makes this an OR-mux.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    always_comb begin
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_onehot[i] = (grant_id == IDX_W'(i));
        end
    end

    // Priority moves to the requester after the one just served.
    assign next_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // mem_req_addr/write/wdata double as the request latch: they are loaded
    // at grant time and held until the next grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            wd_cnt         <= '0;
            grant_id       <= '0;
            rsp_valid      <= '0;
            rsp_error      <= 1'b0;
            rsp_data       <= '0;
            timeout_sticky <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_write  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_id      <= arb_index;
                        mem_req_addr  <= ADDR_WIDTH'(line_align(64'(sel_addr)));
                        mem_req_write <= sel_write;
                        mem_req_wdata <= sel_wdata;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wd_cnt        <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // The response is tested first so it wins over a watchdog
                    // expiry landing on the same cycle.
                    if (mem_rsp_valid) begin
                        rsp_valid <= owner_onehot;
                        if (!mem_req_write) begin
                            rsp_data <= mem_rsp_data;
                        end
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid      <= owner_onehot;
                        rsp_error      <= 1'b1;
                        timeout_sticky <= 1'b1;
                        rr_ptr         <= next_ptr;
                        state          <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_wdata;
    logic              rsp_error;
    logic [LW-1:0]     rsp_data;
    logic              mem_req_valid, mem_req_ready, mem_req_write;
    logic [AW-1:0]     mem_req_addr;
    logic [LW-1:0]     mem_req_wdata, mem_rsp_data;
    logic              mem_rsp_valid, timeout_sticky;
    logic [1:0]        grant_id;

    mem_bus_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .timeout_sticky(timeout_sticky),
        .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } iss_t;

    typedef struct {
        logic [N-1:0]  vec;
        logic          err;
        logic [LW-1:0] data;
        int            c;
    } rsp_t;

    // ---------------- MEM_core behavioural model ----------------
    logic [LW-1:0] mem_arr [int];
    int  lat_q[$];
    int  stall_q[$];
    int  acc_q[$];
    int  spur_cnt = 0;
    bit  busy = 0, loaded = 0, cur_write = 0;
    int  cur_lat = 0, wcnt = 0, stall_left = 0, cur_line = 0, rsp_drive_cyc = 0;

    function automatic logic [LW-1:0] mem_rd(input int k);
        return mem_arr.exists(k) ? mem_arr[k] : '0;
    endfunction

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (!reset) begin
                busy   = 0;
                loaded = 0;
            end else begin
                if (busy) begin
                    if (rsp_valid != '0) begin
                        busy = 0;
                    end else if (cur_lat >= 0) begin
                        if (wcnt == cur_lat) begin
                            mem_rsp_valid = 1'b1;
                            mem_rsp_data  = cur_write ? {$urandom, $urandom, $urandom, $urandom}
                                                      : mem_rd(cur_line);
                            rsp_drive_cyc = cyc;
                            busy = 0;
                        end else begin
                            wcnt++;
                        end
                    end
                end else if (spur_cnt > 0) begin
                    spur_cnt--;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!busy && mem_req_valid) begin
                    if (!loaded) begin
                        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                        loaded = 1;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_req_ready = 1'b1;
                        cur_line  = int'(mem_req_addr >> 4);
                        cur_write = mem_req_write;
                        if (mem_req_write) mem_arr[cur_line] = mem_req_wdata;
                        cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                        busy    = 1;
                        wcnt    = 0;
                        loaded  = 0;
                        acc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    // ---------------- monitors ----------------
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    logic prev_mrv = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (mem_req_valid && !prev_mrv)
                iss_q.push_back('{int'(grant_id), mem_req_write, mem_req_addr, mem_req_wdata});
            prev_mrv = mem_req_valid;
            if (rsp_valid != '0)
                rsp_q.push_back('{rsp_valid, rsp_error, rsp_data, cyc});
        end
    end

    // ---------------- requesters and reference model ----------------
    txn_t pq [N][$];
    logic [LW-1:0] shadow [int];
    int            m_ptr = 0;
    logic [LW-1:0] m_data = '0;

    function automatic logic [LW-1:0] shadow_rd(input int k);
        return shadow.exists(k) ? shadow[k] : '0;
    endfunction

    task automatic preload(input int k, input logic [LW-1:0] v);
        mem_arr[k] = v;
        shadow[k]  = v;
    endtask

    task automatic step();
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_write[i]          = pq[i][0].wr;
                req_addr[i*AW +: AW]  = pq[i][0].addr;
                req_wdata[i*LW +: LW] = pq[i][0].wdata;
            end else begin
                req_valid[i]         = 1'b0;
                req_addr[i*AW +: AW] = $urandom;
            end
        end
        #1;
        check("ready_onehot", ($countones(req_ready) <= 1), 1);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                check("ready_needs_valid", req_valid[i], 1);
                void'(pq[i].pop_front());
            end
        end
    endtask

    // Expected service order: every requester with queued work stays valid,
    // so each decision is the first non-empty queue at or after the pointer.
    task automatic run_batch(input string tag, input int budget);
        txn_t          cp [N][$];
        int            e_id[$];
        txn_t          e_tx[$];
        logic [LW-1:0] e_data[$];
        int            total = 0;
        int            n = 0;
        for (int i = 0; i < N; i++) begin
            cp[i] = pq[i];
            total += pq[i].size();
        end
        for (int t = 0; t < total; t++) begin
            int   j = -1;
            txn_t tx;
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (j < 0 && cp[c].size() > 0) j = c;
            end
            tx = cp[j].pop_front();
            if (tx.wr) shadow[int'(tx.addr >> 4)] = tx.wdata;
            else       m_data = shadow_rd(int'(tx.addr >> 4));
            e_id.push_back(j);
            e_tx.push_back(tx);
            e_data.push_back(m_data);
            m_ptr = (j + 1) % N;
        end
        iss_q.delete();
        rsp_q.delete();
        while (rsp_q.size() < total && n < budget) begin
            step();
            n++;
        end
        check({tag, "_rsp_count"}, rsp_q.size(), total);
        check({tag, "_iss_count"}, iss_q.size(), total);
        for (int k = 0; k < total; k++) begin
            if (k < iss_q.size()) begin
                check({tag, "_grant"}, iss_q[k].id, e_id[k]);
                check({tag, "_addr"}, iss_q[k].addr, e_tx[k].addr & ~32'hF);
                check({tag, "_write"}, iss_q[k].wr, e_tx[k].wr);
                if (e_tx[k].wr) check({tag, "_wdata"}, iss_q[k].wdata, e_tx[k].wdata);
            end
            if (k < rsp_q.size()) begin
                check({tag, "_rsp_vec"}, rsp_q[k].vec, N'(1) << e_id[k]);
                check({tag, "_rsp_err"}, rsp_q[k].err, 0);
                check({tag, "_rsp_data"}, rsp_q[k].data, e_data[k]);
            end
        end
    endtask

    task automatic expect_rsp(input string tag, input logic [N-1:0] ev, input logic ee,
                              input logic [LW-1:0] ed);
        int n = 0;
        while (rsp_valid == '0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_vec"}, rsp_valid, ev);
        check({tag, "_err"}, rsp_error, ee);
        check({tag, "_data"}, rsp_data, ed);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global time limit");
    end

    localparam logic [LW-1:0] L0   = 128'h00000003_00000002_00000001_00000000;
    localparam logic [LW-1:0] LDEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    initial begin
        int n;
        logic [LW-1:0] lbp;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        // ---- reset values, with all requesters asserting during reset ----
        repeat (2) @(negedge clock);
        req_valid = '1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_sticky", timeout_sticky, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_mem_wdata", mem_req_wdata, 0);
        @(negedge clock);
        req_valid = '0;
        reset = 1'b1;

        // ---- single read with latency checks ----
        preload(32'h180, L0);
        @(negedge clock);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0 +: AW] = 32'h1804;
        #1;
        check("rd_req_ready", req_ready, 3'b001);
        @(negedge clock);
        req_valid = '0;
        check("rd_mem_valid", mem_req_valid, 1);
        check("rd_mem_addr", mem_req_addr, 32'h1800);
        check("rd_mem_write", mem_req_write, 0);
        check("rd_grant_id", grant_id, 0);
        expect_rsp("rd", 3'b001, 1'b0, L0);
        check("rd_rsp_latency", cyc, rsp_drive_cyc + 1);
        m_ptr = 1;
        m_data = L0;

        // ---- contention from reset ----
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
        m_data = '0;
        pq[0].push_back('{1'b0, 32'h1804, '0});
        pq[0].push_back('{1'b0, 32'h1a04, '0});
        pq[1].push_back('{1'b0, 32'h1810, '0});
        pq[1].push_back('{1'b0, 32'h180c, '0});
        run_batch("contend", 200);

        // ---- write then read ----
        pq[1].push_back('{1'b1, 32'h1810, LDEF});
        run_batch("wr", 100);
        pq[0].push_back('{1'b0, 32'h1810, '0});
        run_batch("rd_after_wr", 100);

        // ---- stray responses while idle ----
        spur_cnt = 3;
        repeat (5) begin
            @(negedge clock);
            check("spur_idle_rsp", rsp_valid, 0);
            check("spur_idle_mem_valid", mem_req_valid, 0);
            check("spur_idle_data", rsp_data, m_data);
        end

        // ---- backpressure, with stray responses during ISSUE ----
        lbp = {$urandom, $urandom, $urandom, $urandom};
        preload(32'h2a3, lbp);
        stall_q.push_back(5);
        @(negedge clock);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        req_addr[2*AW +: AW] = 32'h2a3c;
        #1;
        check("bp_req_ready", req_ready, 3'b100);
        spur_cnt = 2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            req_valid = '0;
            check("bp_mem_valid", mem_req_valid, 1);
            check("bp_mem_addr", mem_req_addr, 32'h2a30);
            check("bp_no_rsp", rsp_valid, 0);
        end
        @(negedge clock);
        check("bp_accepted", mem_req_valid, 0);
        expect_rsp("bp", 3'b100, 1'b0, lbp);
        m_ptr = 0;
        m_data = lbp;

        // ---- watchdog abort then next requester ----
        acc_q.delete();
        iss_q.delete();
        rsp_q.delete();
        lat_q.push_back(-1);
        lat_q.push_back(0);
        pq[0].push_back('{1'b0, 32'h1800, '0});
        pq[1].push_back('{1'b0, 32'h1810, '0});
        n = 0;
        while (rsp_q.size() < 2 && n < 100) begin
            step();
            n++;
        end
        check("to_rsp_count", rsp_q.size(), 2);
        check("to_sticky", timeout_sticky, 1);
        if (rsp_q.size() > 0 && acc_q.size() > 0) begin
            check("to_vec", rsp_q[0].vec, 3'b001);
            check("to_err", rsp_q[0].err, 1);
            check("to_latency", rsp_q[0].c, acc_q[0] + 1 + TO);
        end
        if (iss_q.size() > 1) check("to_next_grant", iss_q[1].id, 1);
        if (rsp_q.size() > 1) begin
            check("to_next_vec", rsp_q[1].vec, 3'b010);
            check("to_next_err", rsp_q[1].err, 0);
            check("to_next_data", rsp_q[1].data, LDEF);
        end
        m_ptr = 2;
        m_data = LDEF;

        // ---- response on the watchdog expiry cycle wins ----
        lat_q.push_back(TO - 1);
        pq[1].push_back('{1'b0, 32'h1800, '0});
        run_batch("race", 100);
        check("race_sticky_kept", timeout_sticky, 1);

        // ---- reset in the middle of WAIT ----
        lat_q.push_back(-1);
        pq[2].push_back('{1'b0, 32'h1800, '0});
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        check("rstw_accepted", busy, 1);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rstw_mem_valid", mem_req_valid, 0);
        check("rstw_rsp_valid", rsp_valid, 0);
        check("rstw_grant_id", grant_id, 0);
        check("rstw_sticky", timeout_sticky, 0);
        check("rstw_rsp_data", rsp_data, 0);
        check("rstw_mem_addr", mem_req_addr, 0);
        rsp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        lat_q.delete();
        stall_q.delete();
        m_ptr = 0;
        m_data = '0;
        repeat (3) @(negedge clock);
        check("rstw_no_pulse", rsp_q.size(), 0);

        // ---- randomized traffic, all requesters busy ----
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 6; k++) begin
                logic [AW-1:0] a;
                a = 32'h2000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
                pq[i].push_back('{1'($urandom_range(0, 1)), a,
                                  {$urandom, $urandom, $urandom, $urandom}});
            end
        end
        for (int k = 0; k < 6 * N; k++) begin
            lat_q.push_back($urandom_range(0, TO - 2));
            stall_q.push_back($urandom_range(0, 3));
        end
        run_batch("rand", 2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
